// File: rtl/sao_lcu_feeder_pkg.sv
// Shared SAO feeder definitions: LCU size codes, parameter-word field layout,
// feeder FSM states and the default frame width.
package sao_lcu_feeder_pkg;

  localparam int unsigned IMG_W_DEF = 128;

  typedef enum logic [1:0] {
    LCU_16 = 2'd0,
    LCU_32 = 2'd1,
    LCU_64 = 2'd2
  } lcu_size_e;

  localparam int unsigned PAR_TYPE_LSB = 22;
  localparam int unsigned PAR_TYPE_W   = 2;
  localparam int unsigned PAR_BAND_LSB = 17;
  localparam int unsigned PAR_BAND_W   = 5;
  localparam int unsigned PAR_EO_LSB   = 16;
  localparam int unsigned PAR_EO_W     = 1;
  localparam int unsigned PAR_OFS_LSB  = 0;
  localparam int unsigned PAR_OFS_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREQ,
    S_PWAIT,
    S_STREAM,
    S_DONE
  } feed_state_e;

  // The unused code 3 falls back to the smallest LCU.
  function automatic lcu_size_e norm_size(input logic [1:0] cfg);
    return (cfg == 2'd3) ? LCU_16 : lcu_size_e'(cfg);
  endfunction

endpackage

// File: rtl/sao_skid_buf.sv
// Two-entry 8-bit FIFO with valid/ready on both sides; absorbs the one-cycle
// SRAM read latency so the feeder can stall instantly on SAO backpressure.
module sao_skid_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  input  logic       out_ready_i,
  output logic [1:0] count_o
);

  logic [7:0] mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] cnt_q;
  logic       push, pop;

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign in_ready_o  = (cnt_q != 2'd2) | out_ready_i;
  assign count_o     = cnt_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/sao_lcu_feeder.sv
// Walks a square frame LCU by LCU, fetches each LCU's SAO parameters and streams
// its pixels to the SAO core. Optional per-LCU checksum: SAO_FEED_CKSUM_EN.
module sao_lcu_feeder
  import sao_lcu_feeder_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  cfg_lcu_size,
  output logic        img_rd,
  output logic [13:0] img_addr,
  input  logic [7:0]  img_q,
  output logic        par_rd,
  output logic [5:0]  par_addr,
  input  logic [23:0] par_q,
  output logic        in_en,
  output logic [7:0]  din,
  output logic [1:0]  sao_type,
  output logic [4:0]  sao_band_pos,
  output logic        sao_eo_class,
  output logic [15:0] sao_offset,
  output logic [2:0]  lcu_x,
  output logic [2:0]  lcu_y,
  output logic [1:0]  lcu_size,
  input  logic        busy,
  output logic        done
`ifdef SAO_FEED_CKSUM_EN
  ,
  output logic [15:0] lcu_cksum,
  output logic        cksum_vld
`endif
);

  feed_state_e state_q, state_d;
  lcu_size_e   size_q;

  logic [2:0]  sh;
  logic [11:0] last_idx;
  logic [5:0]  col_mask;
  logic [2:0]  n_m1;
  logic [5:0]  n_lcu;

  logic [2:0]  cur_x_q, cur_y_q;
  logic [11:0] rd_idx_q, acc_idx_q;
  logic        rd_all_q, rd_vld_q, first_q;
  logic [23:0] pend_q, out_par_q;
  logic [2:0]  out_x_q, out_y_q;

  logic [5:0]  row, col;
  logic [13:0] y_pix, x_pix;
  logic        buf_in_rdy, buf_valid, push, pop, issue, last_acc, lcu_last;
  logic [7:0]  buf_data;
  logic [1:0]  buf_cnt, slots;

  always_comb begin
    sh       = 3'd4;
    last_idx = 12'd255;
    col_mask = 6'd15;
    case (size_q)
      LCU_32: begin
        sh       = 3'd5;
        last_idx = 12'd1023;
        col_mask = 6'd31;
      end
      LCU_64: begin
        sh       = 3'd6;
        last_idx = 12'd4095;
        col_mask = 6'd63;
      end
      default: ;
    endcase
  end

  assign n_lcu    = 6'(IMG_W >> sh);
  assign n_m1     = 3'((IMG_W >> sh) - 1);
  assign lcu_last = (cur_x_q == n_m1) && (cur_y_q == n_m1);

  assign row      = 6'(rd_idx_q >> sh);
  assign col      = 6'(rd_idx_q) & col_mask;
  assign y_pix    = (14'(cur_y_q) << sh) + 14'(row);
  assign x_pix    = (14'(cur_x_q) << sh) + 14'(col);
  assign img_addr = y_pix * 14'(IMG_W) + x_pix;
  assign par_addr = 6'(cur_y_q) * n_lcu + 6'(cur_x_q);

  // A read may issue only if its data will find a free slot on return: entries
  // held plus the one in flight, less the one leaving this cycle, must be < 2.
  assign in_en    = buf_valid;
  assign din      = buf_data;
  assign pop      = buf_valid & ~busy;
  assign push     = rd_vld_q & buf_in_rdy;
  assign slots    = buf_cnt + {1'b0, rd_vld_q};
  assign issue    = (state_q == S_STREAM) && !rd_all_q && ((slots != 2'd2) || pop);
  assign img_rd   = issue;
  assign last_acc = pop && (acc_idx_q == last_idx);

  assign par_rd   = (state_q == S_PREQ);
  assign done     = (state_q == S_DONE);
  assign lcu_size = size_q;
  assign lcu_x    = out_x_q;
  assign lcu_y    = out_y_q;

  assign sao_type     = out_par_q[PAR_TYPE_LSB +: PAR_TYPE_W];
  assign sao_band_pos = out_par_q[PAR_BAND_LSB +: PAR_BAND_W];
  assign sao_eo_class = out_par_q[PAR_EO_LSB   +: PAR_EO_W];
  assign sao_offset   = out_par_q[PAR_OFS_LSB  +: PAR_OFS_W];

  sao_skid_buf u_skid (
    .clk         (clk),
    .rst_n       (reset),
    .clr_i       (state_q == S_IDLE),
    .in_valid_i  (rd_vld_q),
    .in_data_i   (img_q),
    .in_ready_o  (buf_in_rdy),
    .out_valid_o (buf_valid),
    .out_data_o  (buf_data),
    .out_ready_i (~busy),
    .count_o     (buf_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_PREQ;
      S_PREQ:   state_d = S_PWAIT;
      S_PWAIT:  state_d = S_STREAM;
      S_STREAM: if (last_acc) state_d = lcu_last ? S_DONE : S_PREQ;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      size_q    <= LCU_16;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      rd_idx_q  <= '0;
      acc_idx_q <= '0;
      rd_all_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      first_q   <= 1'b0;
      pend_q    <= '0;
      out_par_q <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
    end else begin
      rd_vld_q <= issue;
      if (state_q == S_IDLE && start) begin
        size_q  <= norm_size(cfg_lcu_size);
        cur_x_q <= '0;
        cur_y_q <= '0;
      end
      if (state_q == S_PREQ) begin
        rd_idx_q  <= '0;
        acc_idx_q <= '0;
        rd_all_q  <= 1'b0;
      end
      if (state_q == S_PWAIT) begin
        pend_q  <= par_q;
        first_q <= 1'b1;
      end
      if (issue) begin
        rd_idx_q <= rd_idx_q + 12'd1;
        if (rd_idx_q == last_idx) rd_all_q <= 1'b1;
      end
      if (pop) begin
        acc_idx_q <= acc_idx_q + 12'd1;
      end
      if (last_acc) begin
        if (cur_x_q == n_m1) begin
          cur_x_q <= '0;
          cur_y_q <= cur_y_q + 3'd1;
        end else begin
          cur_x_q <= cur_x_q + 3'd1;
        end
      end
      // Visible LCU attributes switch in the same edge that makes the first
      // pixel of the new LCU visible; the buffer is empty at that point.
      if (push && first_q) begin
        out_par_q <= pend_q;
        out_x_q   <= cur_x_q;
        out_y_q   <= cur_y_q;
        first_q   <= 1'b0;
      end
    end
  end

`ifdef SAO_FEED_CKSUM_EN
  logic [15:0] cksum_q;
  logic        cksum_vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cksum_q     <= '0;
      cksum_vld_q <= 1'b0;
    end else begin
      cksum_vld_q <= last_acc;
      if (pop) begin
        cksum_q <= ((acc_idx_q == 12'd0) ? 16'd0 : cksum_q) + 16'(din);
      end
    end
  end

  assign lcu_cksum = cksum_q;
  assign cksum_vld = cksum_vld_q;
`endif

endmodule

// File: tb/tb_sao_lcu_feeder.sv
// Self-checking bench for sao_lcu_feeder: SRAM models, randomized backpressure
// and a frame-walk reference model of the expected pixel/parameter stream.
module tb_sao_lcu_feeder;

  localparam int W = 128;

  logic        clk = 1'b0;
  logic        reset, start, busy;
  logic [1:0]  cfg;
  logic        img_rd, par_rd, in_en, done, sao_eo_class;
  logic [13:0] img_addr;
  logic [7:0]  img_q = '0;
  logic [5:0]  par_addr;
  logic [23:0] par_q = '0;
  logic [7:0]  din;
  logic [1:0]  sao_type, lcu_size;
  logic [4:0]  sao_band_pos;
  logic [15:0] sao_offset;
  logic [2:0]  lcu_x, lcu_y;
`ifdef SAO_FEED_CKSUM_EN
  logic [15:0] lcu_cksum;
  logic        cksum_vld;
`endif

  logic [7:0]  img_mem [W*W];
  logic [23:0] par_mem [64];

  int checks = 0;
  int passes = 0;

  int S, N, szn, total, xfer_n, rd_n, done_n, cyc, probe_idx, probe_val;
  bit hold_prev, lcu_seen, all_ff;
  logic [7:0]  p_din;
  logic [23:0] p_par, last_par;
  logic [5:0]  p_xy, last_xy;
  logic [15:0] run_sum;
  int cksum_n;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (img_rd) img_q <= img_mem[img_addr];
    if (par_rd) par_q <= par_mem[par_addr];
  end

  sao_lcu_feeder #(.IMG_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_lcu_size (cfg),
    .img_rd       (img_rd),
    .img_addr     (img_addr),
    .img_q        (img_q),
    .par_rd       (par_rd),
    .par_addr     (par_addr),
    .par_q        (par_q),
    .in_en        (in_en),
    .din          (din),
    .sao_type     (sao_type),
    .sao_band_pos (sao_band_pos),
    .sao_eo_class (sao_eo_class),
    .sao_offset   (sao_offset),
    .lcu_x        (lcu_x),
    .lcu_y        (lcu_y),
    .lcu_size     (lcu_size),
    .busy         (busy),
`ifdef SAO_FEED_CKSUM_EN
    .lcu_cksum    (lcu_cksum),
    .cksum_vld    (cksum_vld),
`endif
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Frame walk: LCUs raster order, pixels raster order inside each LCU.
  function automatic int exp_lx(input int n);
    return (n / (S * S)) % N;
  endfunction

  function automatic int exp_ly(input int n);
    return (n / (S * S)) / N;
  endfunction

  function automatic int exp_addr(input int n);
    int k;
    k = n % (S * S);
    return (exp_ly(n) * S + k / S) * W + exp_lx(n) * S + k % S;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 32'({in_en, img_rd, par_rd, done}), 32'd0);
    chk({tag, "_din"},  32'(din), 32'd0);
    chk({tag, "_par"},  32'({sao_type, sao_band_pos, sao_eo_class, sao_offset}), 32'd0);
    chk({tag, "_xy"},   32'({lcu_x, lcu_y, lcu_size}), 32'd0);
    chk({tag, "_addr"}, 32'({img_addr, par_addr}), 32'd0);
  endtask

  task automatic observe();
    int a, lx, ly, k;
    logic [23:0] par_now;
    par_now = {sao_type, sao_band_pos, sao_eo_class, sao_offset};
    if (hold_prev) begin
      chk("hold_en",  32'(in_en), 32'd1);
      chk("hold_din", 32'(din), 32'(p_din));
      chk("hold_par", 32'(par_now), 32'(p_par));
      chk("hold_xy",  32'({lcu_x, lcu_y}), 32'(p_xy));
    end
`ifdef SAO_FEED_CKSUM_EN
    if (cksum_vld) begin
      cksum_n++;
      chk("cksum", 32'(lcu_cksum), 32'(run_sum));
      if (all_ff) chk("cksum_ff", 32'(lcu_cksum), 32'hFF00);
    end
`endif
    if (img_rd) begin
      chk("rd_in_range", 32'(rd_n < total), 32'd1);
      if (rd_n < total) chk("img_addr", 32'(img_addr), 32'(exp_addr(rd_n)));
      if (rd_n == probe_idx) chk("addr_probe", 32'(img_addr), 32'(probe_val));
      rd_n++;
    end
    if (in_en && !busy) begin
      chk("xfer_in_range", 32'(xfer_n < total), 32'd1);
      if (xfer_n < total) begin
        a  = exp_addr(xfer_n);
        lx = exp_lx(xfer_n);
        ly = exp_ly(xfer_n);
        k  = xfer_n % (S * S);
        chk("din",      32'(din), 32'(img_mem[a]));
        chk("lcu_xy",   32'({lcu_x, lcu_y}), 32'(lx * 8 + ly));
        chk("sao_par",  32'(par_now), 32'(par_mem[ly * N + lx]));
        chk("lcu_size", 32'(lcu_size), 32'(szn));
        if (S == 32 && lx == 1 && ly == 2 && k == 0)
          chk("lcu12_first_par", 32'(par_now), 32'h8FA5C3);
        run_sum = (k == 0) ? 16'(img_mem[a]) : run_sum + 16'(img_mem[a]);
      end
      last_par = par_now;
      last_xy  = {lcu_x, lcu_y};
      lcu_seen = 1'b1;
      xfer_n++;
    end else if (!in_en && lcu_seen) begin
      chk("gap_par", 32'(par_now), 32'(last_par));
      chk("gap_xy",  32'({lcu_x, lcu_y}), 32'(last_xy));
    end
    hold_prev = in_en && busy;
    p_din     = din;
    p_par     = par_now;
    p_xy      = {lcu_x, lcu_y};
    if (done) begin
      done_n++;
      chk("done_after_last", 32'(xfer_n), 32'(total));
    end
  endtask

  task automatic cycle(input int busy_pct);
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    start = 1'b0;
    busy  = ($urandom_range(99) < busy_pct);
    cyc++;
  endtask

  // Called just after a rising edge; max_xfer < total stops the frame early.
  task automatic run_frame(input logic [1:0] cfg_v, input int busy_pct, input int max_xfer,
                           input bit poke, input int p_idx, input int p_val);
    int budget;
    bit poked;
    szn       = (cfg_v == 2'd3) ? 0 : int'(cfg_v);
    S         = 16 << szn;
    N         = W / S;
    total     = W * W;
    xfer_n    = 0;
    rd_n      = 0;
    done_n    = 0;
    cyc       = 0;
    cksum_n   = 0;
    hold_prev = 1'b0;
    lcu_seen  = 1'b0;
    poked     = 1'b0;
    probe_idx = p_idx;
    probe_val = p_val;
    budget    = 3 * total + 1000;
    cfg       = cfg_v;
    start     = 1'b1;
    cycle(busy_pct);
    while (done_n == 0 && xfer_n < max_xfer && cyc < budget) begin
      if (poke && !poked && xfer_n >= 1000) begin
        start = 1'b1;
        cfg   = 2'd2;
        poked = 1'b1;
      end
      cycle(busy_pct);
    end
    chk("frame_budget", 32'(cyc < budget), 32'd1);
    if (max_xfer >= total) begin
      if (busy_pct == 0) chk("throughput", 32'(cyc <= total + N * N * 6 + 20), 32'd1);
      repeat (4) cycle(busy_pct);
      chk("xfer_total", 32'(xfer_n), 32'(total));
      chk("rd_total",   32'(rd_n), 32'(total));
      chk("done_count", 32'(done_n), 32'd1);
`ifdef SAO_FEED_CKSUM_EN
      chk("cksum_count", 32'(cksum_n), 32'(N * N));
`endif
    end
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    busy   = 1'b0;
    cfg    = 2'd0;
    all_ff = 1'b0;
    for (int i = 0; i < W * W; i++) img_mem[i] = 8'(i);
    for (int i = 0; i < 64; i++) par_mem[i] = 24'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Ramp image, 16x16, no backpressure, with a start pulse mid-frame.
    run_frame(2'd0, 0, W * W, 1'b1, -1, 0);

    // Random image, 32x32, 50% backpressure, marked parameters on LCU (1,2).
    for (int i = 0; i < W * W; i++) img_mem[i] = 8'($urandom);
    par_mem[2 * 4 + 0] = 24'h123456;
    par_mem[2 * 4 + 1] = {2'b10, 5'd7, 1'b1, 16'hA5C3};
    run_frame(2'd1, 50, W * W, 1'b0, -1, 0);

    // 64x64: first read of LCU (1,1) is the 3*4096-th read.
    run_frame(2'd2, 0, W * W, 1'b0, 3 * 4096, 8256);

`ifdef SAO_FEED_CKSUM_EN
    for (int i = 0; i < W * W; i++) img_mem[i] = 8'hFF;
    all_ff = 1'b1;
    run_frame(2'd0, 0, W * W, 1'b0, -1, 0);
    all_ff = 1'b0;
    for (int i = 0; i < W * W; i++) img_mem[i] = 8'(i);
`endif

    // Reset at transfer 5000, then restart with size code 3 (treated as 16x16).
    run_frame(2'd0, 0, 5000, 1'b0, -1, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    reset = 1'b1;
    busy  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("idle_no_xfer", 32'({in_en, img_rd, par_rd}), 32'd0);
    end
    @(posedge clk);
    #1;
    run_frame(2'd3, 0, 600, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
